// File: rtl/adc_window_accumulator.sv
// ADC window accumulator: integrates samples over each adc_en window and queues
// one {rot, ch, cnt, sum, err} record per window into a 4-deep FWFT FIFO.
module adc_window_accumulator #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 24,
  parameter int unsigned SUM_W  = 40
) (
  input  logic              fpga_clk,
  input  logic              sys_rst_n,
  input  logic              sys_init_ctrl,
  input  logic              adc_en,
  input  logic [3:0]        rf_sw,
  input  logic [9:0]        rot_count,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [9:0]        rec_rot,
  output logic [1:0]        rec_ch,
  output logic [CNT_W-1:0]  rec_cnt,
  output logic [SUM_W-1:0]  rec_sum,
  output logic              rec_err,
  output logic [7:0]        drop_count
);

  localparam int unsigned RecW = 10 + 2 + CNT_W + SUM_W + 1;

  typedef enum logic [1:0] {StIdle, StAccum, StClose} state_e;

  state_e             state_q, state_d;
  logic               adc_en_d;
  logic [9:0]         rot_q, rot_d;
  logic [3:0]         rf_q, rf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               err_q, err_d;
  logic [SUM_W:0]     sum_ext;
  logic [1:0]         ch;
  logic               ch_bad;
  logic               push;

  logic [RecW-1:0]    mem [4];
  logic [1:0]         wr_ptr_q, rd_ptr_q;
  logic [2:0]         fifo_cnt_q;
  logic               full, pop, wr_en, drop;
  logic [RecW-1:0]    rec_in;

  // Extra top bit catches sum overflow so it can saturate instead of wrapping
  assign sum_ext = {1'b0, sum_q} + {{(SUM_W + 1 - DATA_W){1'b0}}, adc_data};

  // Channel decode of the latched switch; anything not one-hot is an error
  always_comb begin
    ch     = 2'd0;
    ch_bad = 1'b0;
    case (rf_q)
      4'b0001: ch = 2'd0;
      4'b0010: ch = 2'd1;
      4'b0100: ch = 2'd2;
      4'b1000: ch = 2'd3;
      default: ch_bad = 1'b1;
    endcase
  end

  // Window FSM next-state and accumulator update
  always_comb begin
    state_d = state_q;
    rot_d   = rot_q;
    rf_d    = rf_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    err_d   = err_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (adc_en && !adc_en_d) begin
          rot_d   = rot_count;
          rf_d    = rf_sw;
          cnt_d   = '0;
          sum_d   = '0;
          err_d   = 1'b0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (rf_sw != rf_q) err_d = 1'b1;
        if (!adc_en) begin
          state_d = StClose;
        end else if (adc_valid) begin
          if (&cnt_q) err_d = 1'b1;
          else        cnt_d = cnt_q + CNT_W'(1);
          if (sum_ext[SUM_W]) begin
            sum_d = '1;
            err_d = 1'b1;
          end else begin
            sum_d = sum_ext[SUM_W-1:0];
          end
        end
      end
      StClose: begin
        push    = !sys_init_ctrl;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and window registers; init abandons the window and re-primes edge detect
  always_ff @(posedge fpga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= StIdle;
      adc_en_d <= 1'b0;
      rot_q    <= '0;
      rf_q     <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      err_q    <= 1'b0;
    end else if (sys_init_ctrl) begin
      state_q  <= StIdle;
      adc_en_d <= adc_en;
      rot_q    <= '0;
      rf_q     <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      adc_en_d <= adc_en;
      rot_q    <= rot_d;
      rf_q     <= rf_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      err_q    <= err_d;
    end
  end

  assign rec_in    = {rot_q, ch, cnt_q, sum_q, err_q | ch_bad};
  assign rec_valid = (fifo_cnt_q != 3'd0);
  assign full      = (fifo_cnt_q == 3'd4);
  assign pop       = rec_valid && rec_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;

  // FIFO pointers, occupancy and drop counter
  always_ff @(posedge fpga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      drop_count <= '0;
    end else if (sys_init_ctrl) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      drop_count <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({wr_en, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      if (drop && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
    end
  end

  // FIFO storage; contents are only visible while non-empty so no reset needed
  always_ff @(posedge fpga_clk) begin
    if (wr_en) mem[wr_ptr_q] <= rec_in;
  end

  assign {rec_rot, rec_ch, rec_cnt, rec_sum, rec_err} = rec_valid ? mem[rd_ptr_q] : '0;

endmodule
